// File: rtl/pc_pkg.sv
// Shared operation encoding for the program counter and its controller.
package pc_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        HOLD   = 3'd0,
        INC    = 3'd1,
        SKIP   = 3'd2,
        JMP    = 3'd3,
        BRANCH = 3'd4,
        CALL   = 3'd5,
        RET    = 3'd6
    } pc_op_t;

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO. Push-when-full and pop-when-empty are ignored internally;
// entries are only written on a successful push and are never cleared by a pop.
module pc_stack #(
    parameter int W       = 5,
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [W-1:0]       din,
    output logic [W-1:0]       dout,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]       mem_q [DEPTH];
    logic [W-1:0]       mem_d [DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [DEPTH_W-1:0] depth_m1;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               do_push, do_pop;

    assign full  = (depth_q == DEPTH_W'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    // Next free slot is indexed by depth itself; the top entry sits one below.
    assign depth_m1 = depth_q - DEPTH_W'(1);
    assign wr_idx   = depth_q[IDX_W-1:0];
    assign rd_idx   = depth_m1[IDX_W-1:0];
    assign dout     = mem_q[rd_idx];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !push && !empty;
        mem_d   = mem_q;
        depth_d = depth_q;
        if (do_push) begin
            mem_d[wr_idx] = din;
            depth_d       = depth_q + DEPTH_W'(1);
        end else if (do_pop) begin
            depth_d = depth_m1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with skip, PC-relative branch and a hardware call/return stack
// reporting full/empty status and a sticky misuse flag.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 5,
    parameter int                OFF_W       = 4,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  pc_op_t                             op,
    input  logic [ADDR_W-1:0]                  target,
    input  logic [OFF_W-1:0]                   offset,
    input  logic                               clr_err,
    output logic [ADDR_W-1:0]                  pc,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_err
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              err_q, err_d;
    logic              err_set;
    logic              push, pop;
    logic [ADDR_W-1:0] pc_plus1, off_ext, stack_top;

    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign off_ext  = ADDR_W'($signed(offset));

    pc_stack #(
        .W      (ADDR_W),
        .DEPTH  (STACK_DEPTH),
        .DEPTH_W(DEPTH_W)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (pc_plus1),
        .dout (stack_top),
        .depth(depth),
        .full (stack_full),
        .empty(stack_empty)
    );

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (en) begin
            case (op)
                INC:    pc_d = pc_plus1;
                SKIP:   pc_d = pc_q + ADDR_W'(2);
                JMP:    pc_d = target;
                BRANCH: pc_d = pc_q + off_ext;
                CALL: begin
                    if (stack_full) begin
                        err_set = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = target;
                    end
                end
                RET: begin
                    if (stack_empty) begin
                        err_set = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stack_top;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end
        // A new error outranks a simultaneous clear; clear works even when disabled.
        if (err_set) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc        = pc_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Bench for program_counter_stack: default and (ADDR_W=8, depth 1, reset 0xF0) instances
// checked every cycle against a queue-based reference plus hand-computed values.
module tb_program_counter_stack;
    import pc_pkg::*;

    logic clk;
    int   tests = 0;
    int   fails = 0;

    logic       rst_a, en_a, clr_a;
    pc_op_t     op_a;
    logic [4:0] tgt_a, pc_a;
    logic [3:0] off_a;
    logic       full_a, empty_a, err_a;
    logic [2:0] depth_a;

    logic       rst_b, en_b, clr_b;
    pc_op_t     op_b;
    logic [7:0] tgt_b, pc_b;
    logic [3:0] off_b;
    logic       full_b, empty_b, err_b;
    logic [0:0] depth_b;

    program_counter_stack dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .op(op_a), .target(tgt_a), .offset(off_a),
        .clr_err(clr_a), .pc(pc_a), .stack_full(full_a), .stack_empty(empty_a),
        .depth(depth_a), .stack_err(err_a)
    );

    program_counter_stack #(
        .ADDR_W(8), .OFF_W(4), .STACK_DEPTH(1), .RESET_VEC(8'hF0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .op(op_b), .target(tgt_b), .offset(off_b),
        .clr_err(clr_b), .pc(pc_b), .stack_full(full_b), .stack_empty(empty_b),
        .depth(depth_b), .stack_err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one operation applied to an abstract (pc, return list, error) state.
    function automatic void mstep(input int aw, input int cap, input int pcv, input int top,
                                  input int size, input bit en, input int op, input int tgt,
                                  input int off, input bit clr, input bit errv,
                                  output int npc, output bit nerr,
                                  output bit dopush, output bit dopop);
        int  mask = (1 << aw) - 1;
        int  soff = (off >= 8) ? off - 16 : off;
        bit  bad  = 1'b0;
        npc    = pcv;
        dopush = 1'b0;
        dopop  = 1'b0;
        if (en) begin
            if (op == 1) npc = (pcv + 1) & mask;
            else if (op == 2) npc = (pcv + 2) & mask;
            else if (op == 3) npc = tgt;
            else if (op == 4) npc = (pcv + soff) & mask;
            else if (op == 5) begin
                if (size == cap) bad = 1'b1;
                else begin dopush = 1'b1; npc = tgt; end
            end else if (op == 6) begin
                if (size == 0) bad = 1'b1;
                else begin dopop = 1'b1; npc = top; end
            end
        end
        nerr = bad ? 1'b1 : (clr ? 1'b0 : errv);
    endfunction

    int ma_pc = 0;   bit ma_err = 0; int ma_q[$];
    int mb_pc = 240; bit mb_err = 0; int mb_q[$];
    int na_pc, nb_pc; bit na_err, nb_err, pa, qa, pb, qb;

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            ma_pc = 0; ma_err = 0; ma_q.delete();
        end else begin
            mstep(5, 4, ma_pc, (ma_q.size() > 0) ? ma_q[$] : 0, ma_q.size(), en_a, int'(op_a),
                  int'(tgt_a), int'(off_a), clr_a, ma_err, na_pc, na_err, pa, qa);
            if (pa) ma_q.push_back((ma_pc + 1) & 31);
            if (qa) void'(ma_q.pop_back());
            ma_pc = na_pc; ma_err = na_err;
        end
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mb_pc = 240; mb_err = 0; mb_q.delete();
        end else begin
            mstep(8, 1, mb_pc, (mb_q.size() > 0) ? mb_q[$] : 0, mb_q.size(), en_b, int'(op_b),
                  int'(tgt_b), int'(off_b), clr_b, mb_err, nb_pc, nb_err, pb, qb);
            if (pb) mb_q.push_back((mb_pc + 1) & 255);
            if (qb) void'(mb_q.pop_back());
            mb_pc = nb_pc; mb_err = nb_err;
        end
    end

    always @(negedge clk) begin
        chk("a_pc", int'(pc_a), ma_pc);
        chk("a_depth", int'(depth_a), ma_q.size());
        chk("a_full", int'(full_a), int'(ma_q.size() == 4));
        chk("a_empty", int'(empty_a), int'(ma_q.size() == 0));
        chk("a_err", int'(err_a), int'(ma_err));
        chk("b_pc", int'(pc_b), mb_pc);
        chk("b_depth", int'(depth_b), mb_q.size());
        chk("b_full", int'(full_b), int'(mb_q.size() == 1));
        chk("b_empty", int'(empty_b), int'(mb_q.size() == 0));
        chk("b_err", int'(err_b), int'(mb_err));
    end

    // Drive one operation to instance k (0 = default, 1 = wide) while the other idles.
    task automatic cyc(input int k, input bit en, input pc_op_t op, input int tgt,
                       input int off, input bit clr);
        en_a = 1'b0; clr_a = 1'b0; op_a = HOLD;
        en_b = 1'b0; clr_b = 1'b0; op_b = HOLD;
        if (k == 0) begin
            en_a = en; op_a = op; tgt_a = 5'(tgt); off_a = 4'(off); clr_a = clr;
        end else begin
            en_b = en; op_b = op; tgt_b = 8'(tgt); off_b = 4'(off); clr_b = clr;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        en_a = 1'b0; op_a = HOLD; tgt_a = '0; off_a = '0; clr_a = 1'b0;
        en_b = 1'b0; op_b = HOLD; tgt_b = '0; off_b = '0; clr_b = 1'b0;
        #1 rst_a = 1'b0; rst_b = 1'b0;
        #2 rst_a = 1'b1; rst_b = 1'b1;
        chk("rst_pc_a", int'(pc_a), 0);
        chk("rst_empty_a", int'(empty_a), 1);
        chk("rst_pc_b", int'(pc_b), 240);

        // Reset and increment
        cyc(0, 1, JMP, 9, 0, 0);    chk("jmp9", int'(pc_a), 9);
        #2 rst_a = 1'b0;
        #1 chk("async_rst", int'(pc_a), 0);
        rst_a = 1'b1;
        cyc(0, 1, INC, 0, 0, 0);    chk("inc1", int'(pc_a), 1);
        cyc(0, 1, INC, 0, 0, 0);    chk("inc2", int'(pc_a), 2);
        cyc(0, 1, INC, 0, 0, 0);    chk("inc3", int'(pc_a), 3);
        cyc(0, 1, SKIP, 0, 0, 0);   chk("skip", int'(pc_a), 5);
        chk("t1_depth", int'(depth_a), 0);

        // Jump, branch and wrap
        cyc(0, 1, JMP, 21, 0, 0);   chk("jmp21", int'(pc_a), 21);
        cyc(0, 1, BRANCH, 0, 12, 0); chk("br_m4", int'(pc_a), 17);
        cyc(0, 1, JMP, 31, 0, 0);   chk("jmp31", int'(pc_a), 31);
        cyc(0, 1, INC, 0, 0, 0);    chk("inc_wrap", int'(pc_a), 0);
        cyc(0, 1, JMP, 30, 0, 0);
        cyc(0, 1, BRANCH, 0, 3, 0); chk("br_wrap_up", int'(pc_a), 1);
        cyc(0, 1, BRANCH, 0, 12, 0); chk("br_wrap_dn", int'(pc_a), 29);
        cyc(0, 1, JMP, 31, 0, 0);
        cyc(0, 1, SKIP, 0, 0, 0);   chk("skip_wrap", int'(pc_a), 1);
        cyc(0, 1, pc_op_t'(3'd7), 0, 0, 0); chk("op7_hold", int'(pc_a), 1);

        // Nested call/return
        cyc(0, 1, JMP, 2, 0, 0);
        cyc(0, 1, CALL, 10, 0, 0);  chk("call10", int'(pc_a), 10);
        cyc(0, 1, CALL, 20, 0, 0);  chk("call20_d", int'(depth_a), 2);
        cyc(0, 1, RET, 0, 0, 0);    chk("ret11", int'(pc_a), 11);
        cyc(0, 1, RET, 0, 0, 0);    chk("ret3", int'(pc_a), 3);
        chk("ret_empty", int'(empty_a), 1);

        // Overflow, then LIFO unwinding
        cyc(0, 1, CALL, 1, 0, 0);
        cyc(0, 1, CALL, 2, 0, 0);
        cyc(0, 1, CALL, 3, 0, 0);   chk("pre_full", int'(full_a), 0);
        cyc(0, 1, CALL, 4, 0, 0);   chk("full", int'(full_a), 1);
        chk("full_depth", int'(depth_a), 4);
        cyc(0, 1, CALL, 7, 0, 0);   chk("ovf_pc", int'(pc_a), 4);
        chk("ovf_err", int'(err_a), 1);
        cyc(0, 1, HOLD, 0, 0, 0);   chk("err_sticky", int'(err_a), 1);
        cyc(0, 1, HOLD, 0, 0, 1);   chk("err_clr", int'(err_a), 0);
        cyc(0, 1, RET, 0, 0, 0);    chk("pop4", int'(pc_a), 4);
        cyc(0, 1, RET, 0, 0, 0);    chk("pop3", int'(pc_a), 3);
        cyc(0, 1, RET, 0, 0, 0);    chk("pop2", int'(pc_a), 2);
        cyc(0, 1, RET, 0, 0, 0);    chk("pop_last", int'(pc_a), 4);
        cyc(0, 1, JMP, 31, 0, 0);
        cyc(0, 1, CALL, 6, 0, 0);
        cyc(0, 1, RET, 0, 0, 0);    chk("ret_wrap0", int'(pc_a), 0);

        // Underflow and enable
        cyc(0, 1, RET, 0, 0, 0);    chk("udf_pc", int'(pc_a), 0);
        chk("udf_err", int'(err_a), 1);
        cyc(0, 1, HOLD, 0, 0, 1);
        cyc(0, 1, CALL, 9, 0, 0);   chk("call9", int'(pc_a), 9);
        for (int i = 0; i < 3; i++) cyc(0, 0, CALL, 12, 0, 0);
        chk("en0_pc", int'(pc_a), 9);
        chk("en0_depth", int'(depth_a), 1);
        cyc(0, 1, RET, 0, 0, 0);    chk("en0_stack", int'(pc_a), 1);
        cyc(0, 1, RET, 0, 0, 1);    chk("set_beats_clr", int'(err_a), 1);
        cyc(0, 0, HOLD, 0, 0, 1);   chk("clr_when_dis", int'(err_a), 0);

        // Wide, single-entry instance
        cyc(1, 1, CALL, 5, 0, 0);   chk("b_call5", int'(pc_b), 5);
        chk("b_full", int'(full_b), 1);
        cyc(1, 1, CALL, 6, 0, 0);   chk("b_ovf", int'(err_b), 1);
        cyc(1, 1, RET, 0, 0, 0);    chk("b_ret", int'(pc_b), 241);
        cyc(1, 1, JMP, 255, 0, 0);
        cyc(1, 1, INC, 0, 0, 0);    chk("b_wrap", int'(pc_b), 0);

        cyc(0, 1, HOLD, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised next-generation program counter for the simple RISC CPU.
- Adds configurable address width, a reset vector, a skip operation, PC-relative branches, and a hardware call/return stack with full/empty/error status.
- Sits between the controller (which issues one operation per cycle) and the instruction-memory address bus.

Parameters:
- ADDR_W, 5, PC and address width in bits (≥2).
- OFF_W, 4, width of the signed relative-branch offset (≤ADDR_W).
- STACK_DEPTH, 4, number of return-address entries (≥1).
- RESET_VEC, 0, value of pc after reset (ADDR_W bits).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  operation enable; 0 freezes all state.
- op  in  3  operation code, pc_op_t from pc_pkg.
- target  in  ADDR_W  absolute address for JMP and CALL.
- offset  in  OFF_W  signed two's-complement offset for BRANCH.
- clr_err  in  1  clears the sticky stack_err flag.
- pc  out  ADDR_W  current program counter (registered).
- stack_full  out  1  high when depth == STACK_DEPTH.
- stack_empty  out  1  high when depth == 0.
- depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_err  out  1  sticky; set on CALL-when-full or RET-when-empty.

Behaviour:
- Reset (rst=0, asynchronous, any time, including mid-operation):
  - pc=RESET_VEC, depth=0, stack_empty=1, stack_full=0, stack_err=0.
  - Stack contents are don't-care.
- All outputs are registered. An op sampled at edge N is visible on pc and flags after edge N (one-cycle latency).
- en=0: pc, stack, depth and stack_err all hold. clr_err still acts.
- Op encoding (pc_op_t) and effect when en=1:
  - HOLD=0: pc holds.
  - INC=1: pc <= pc+1.
  - SKIP=2: pc <= pc+2.
  - JMP=3: pc <= target.
  - BRANCH=4: pc <= pc + sign_extend(offset).
  - CALL=5: push pc+1; pc <= target; depth+1.
  - RET=6: pc <= top of stack; pop; depth-1.
  - 7: reserved, behaves as HOLD.
- All pc arithmetic is modulo 2^ADDR_W, so wrap-around is silent:
  - INC from all-ones gives 0.
  - SKIP from all-ones gives 1.
  - BRANCH below 0 wraps to the top of the address space.
- CALL when stack_full: no push, pc unchanged, depth unchanged, stack_err <= 1.
- RET when stack_empty: no pop, pc unchanged, stack_err <= 1.
- CALL with depth == STACK_DEPTH-1 succeeds; stack_full rises in the same update.
- stack_err priority: a set event in the same cycle as clr_err=1 wins, so stack_err=1 afterwards.
- The return address pushed is pc+1 modulo 2^ADDR_W. A CALL at the last address pushes 0.
- Stack is strict LIFO. Entries are written only on a successful push. A pop does not clear the entry.
- No combinational path from any input to any output.

Decomposition:
- pc_pkg holds:
  - typedef enum logic [2:0] pc_op_t {HOLD, INC, SKIP, JMP, BRANCH, CALL, RET}.
  - localparam PC_OP_W=3.
- Sub-module pc_stack, a parametrised LIFO (width ADDR_W, depth STACK_DEPTH):
  - Inputs: push, pop, din.
  - Outputs: dout (top of stack), depth, full, empty.
  - Same clk and asynchronous active-low rst.
  - Guards internally against push-when-full and pop-when-empty.
- The top level holds:
  - the pc register,
  - next-pc selection mux,
  - push/pop/error decode,
  - the sticky stack_err register.

Test Plan (defaults ADDR_W=5, STACK_DEPTH=4, RESET_VEC=0 unless stated):
1. Reset and increment: drop rst mid-cycle while pc=9, release, issue INC ×3 then SKIP ×1.
   - pc goes to 0 asynchronously, then 1, 2, 3, 5.
   - depth=0, stack_empty=1.
2. Jump, branch and wrap: JMP target=21, then BRANCH offset=4'b1100 (−4), then JMP 31, then INC.
   - pc = 21, 17, 31, 0.
   - BRANCH offset=4'b0011 from pc=30 gives pc=1.
3. Nested call/return: from pc=2, CALL 10, CALL 20, RET, RET.
   - pc = 10 (depth 1), 20 (depth 2), 11 (depth 1), 3 (depth 0, stack_empty=1).
4. Overflow: 4 CALLs.
   - stack_full=1, depth=4.
   - A 5th CALL target=7 leaves pc and depth unchanged and sets stack_err=1.
   - stack_err stays 1 until clr_err=1 with a HOLD op, then reads 0.
5. Underflow and enable: RET with the stack empty.
   - pc unchanged, stack_err=1.
   - With en=0, drive CALL 12 for 3 cycles: pc, depth and stack unchanged.
   - clr_err with a simultaneous failing RET leaves stack_err=1.
6. Parameter sweep: ADDR_W=8, STACK_DEPTH=1, RESET_VEC=8'hF0.
   - Reset gives pc=240.
   - CALL 5 gives depth=1, full=1.
   - A second CALL sets stack_err.
   - RET gives pc=241.
   - INC from 255 gives pc=0.
